// File: rtl/c2h_stream_packer.sv
// Card-to-host return streamer: buffers non-stallable DDR read beats in a FWFT FIFO
// and emits them as framed AXI4-Stream with tlast every programmed number of beats.
module c2h_stream_packer #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  input  logic                        rd_valid,
  input  logic [DATA_W-1:0]           rd_data,
  input  logic                        rd_last,
  input  logic [CNT_W-1:0]            pkt_beats,
  input  logic                        clr_err,
  output logic [DATA_W-1:0]           M_AXIS_C2H_tdata,
  output logic                        M_AXIS_C2H_tvalid,
  input  logic                        M_AXIS_C2H_tready,
  output logic [DATA_W/8-1:0]         M_AXIS_C2H_tkeep,
  output logic                        M_AXIS_C2H_tlast,
  output logic                        overflow,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic [31:0]                 beat_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  idx, len;
  logic [CNT_W-1:0]  len_eff;
  logic              full, empty, push, pop, drop, beat_last;

  // Pointer-based occupancy; full is judged before any same-cycle pop
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = rd_valid && !full;
  assign drop  = rd_valid && full;
  assign pop   = !empty && M_AXIS_C2H_tready;

  // First beat of a packet uses the freshly sampled length
  assign len_eff   = (idx == '0) ? ((pkt_beats == '0) ? CNT_W'(1) : pkt_beats) : len;
  assign beat_last = rd_last || (idx == len_eff - CNT_W'(1));

  assign M_AXIS_C2H_tvalid = !empty;
  assign M_AXIS_C2H_tdata  = empty ? '0 : mem[rd_ptr[AW-1:0]].data;
  assign M_AXIS_C2H_tlast  = empty ? 1'b0 : mem[rd_ptr[AW-1:0]].last;
  assign M_AXIS_C2H_tkeep  = '1;
  assign fifo_level        = wr_ptr - rd_ptr;

  // Storage array, no reset needed: reads are masked while empty
  always_ff @(posedge axi_aclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{last: beat_last, data: rd_data};
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Input framing advances on every beat, dropped or not
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      idx <= '0;
      len <= CNT_W'(1);
    end else if (rd_valid) begin
      if (idx == '0) len <= len_eff;
      idx <= beat_last ? '0 : idx + CNT_W'(1);
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      overflow   <= 1'b0;
      beat_count <= '0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (pop)          beat_count <= beat_count + 32'd1;
    end
  end

endmodule

// File: doc/c2h_stream_packer.md
# c2h_stream_packer

Return-path (card-to-host) streamer for the SDDT core. It is the counterpart of the host-to-core command stream. It accepts DDR read beats from the readback datapath, which cannot be stalled, and buffers them in a small FIFO. It emits them as a framed AXI4-Stream toward the PS DMA S2MM channel, with tlast every programmed number of beats and a sticky overflow flag exposed on the debug GPIO.

## Interface
Parameters:
- DATA_W, 512, beat width; tkeep width is DATA_W/8.
- DEPTH, 16, FIFO entries; power of two, ≥ 2.
- CNT_W, 16, width of the packet-length input and the internal beat index.

Ports (name, direction, width, meaning):
- axi_aclk, in, 1, single clock for the whole block.
- axi_aresetn, in, 1, reset; asynchronous assert, active-low.
- rd_valid, in, 1, read beat present this cycle; there is no ready signal.
- rd_data, in, DATA_W, read beat payload.
- rd_last, in, 1, forces tlast on this beat (qualified by rd_valid).
- pkt_beats, in, CNT_W, beats per packet; sampled on the first beat of each packet.
- clr_err, in, 1, synchronous clear of overflow.
- M_AXIS_C2H_tdata, out, DATA_W, stream data.
- M_AXIS_C2H_tvalid, out, 1, stream valid.
- M_AXIS_C2H_tready, in, 1, stream ready.
- M_AXIS_C2H_tkeep, out, DATA_W/8, constant all-ones.
- M_AXIS_C2H_tlast, out, 1, packet end.
- overflow, out, 1, sticky: a beat was dropped.
- fifo_level, out, $clog2(DEPTH)+1, current occupancy.
- beat_count, out, 32, count of output handshakes; wraps.

## Operation
- **FIFO storage.** DEPTH × (DATA_W+1) entries; each entry holds data plus its tlast bit.
- **Pointers.** Write and read pointers are $clog2(DEPTH)+1 bits wide.
  - full when the pointers are equal except for the MSB.
  - empty when the pointers are fully equal.
- **Write.** A write occurs on rd_valid && !full.
- **Full rule.** full is evaluated before the same-cycle pop. A beat arriving while full is dropped even if the output pops that cycle.
- **Drop.** A dropped beat sets overflow. The input beat index still advances, so framing stays aligned to the source beat numbering. If the dropped beat would have carried tlast, that tlast is lost.
- **Input framing counter idx (CNT_W bits):**
  - When idx==0 and rd_valid, latch len = (pkt_beats==0 ? 1 : pkt_beats).
  - The effective length on that first beat is the freshly sampled value.
  - Beat tlast = rd_last || (idx == len−1).
  - On every rd_valid: idx ← tlast ? 0 : idx+1.
- **pkt_beats changes mid-packet** have no effect until the next packet start.
- **Output is first-word-fall-through:**
  - tvalid = !empty.
  - tdata and tlast come from the head entry.
  - Pop on tvalid && tready.
- **beat_count** increments on each pop and wraps from 2^32−1 to 0.
- **overflow:**
  - Set on a drop.
  - Cleared by clr_err.
  - A drop and clr_err in the same cycle leaves overflow = 1 (set wins).
- **fifo_level** = wr_ptr − rd_ptr, which is registered state.

## Timing
- Reset values (axi_aresetn low, asynchronous):
  - tvalid = 0, tlast = 0, tdata = 0.
  - overflow = 0, fifo_level = 0, beat_count = 0.
  - idx = 0, len = 1, both pointers = 0.
  - tkeep is all-ones always.
- **Reset deassertion** takes effect on the next clock edge. Reset mid-packet discards all buffered beats and framing state; no partial tlast is emitted.
- **Latency.** A beat written at edge N has tvalid high after edge N, i.e. it is visible during cycle N+1 when the FIFO was empty.
- **AXIS rules:**
  - tdata, tlast and tvalid stay stable while tvalid && !tready.
  - tvalid never depends on tready.
- **Throughput.** With tready held high, one beat per cycle is sustained indefinitely with no drops; at most 1 entry is occupied.
- **Simultaneous push/pop when not full:** level is unchanged.
- **Simultaneous push/pop when full:** the push is dropped and level drops by 1.
- **Pointer wrap.** Pointers wrap modulo 2·DEPTH; data order is preserved across the wrap.

## Test plan
- **Basic framing.** pkt_beats=4, tready=1, 8 consecutive beats with data 0..7.
  - Expect 8 handshakes, tlast on beats 3 and 7, beat_count=8, overflow=0.
- **Forced last and zero length.** pkt_beats=0, 3 beats.
  - Expect tlast on every beat.
  - Then pkt_beats=5 with rd_last on beat 2 → tlast on beat 2, and the next packet restarts at idx 0.
- **Backpressure and overflow.** tready=0, 20 beats (DEPTH=16).
  - Expect fifo_level=16, overflow=1.
  - Then tready=1 → beats 0..15 emitted in order, beats 16..19 absent.
  - clr_err → overflow=0.
- **Stall stability.** Random tready toggling, 100 beats, pkt_beats=7.
  - Expect tdata/tlast held during stalls.
  - Output sequence equals the input sequence; tlast every 7th beat.
- **Full-cycle contention.** FIFO full, rd_valid and pop in the same cycle.
  - Expect the beat dropped, overflow=1, level=15.
  - Same cycle as a clr_err pulse → overflow remains 1.
- **Async reset mid-packet.** Assert axi_aresetn low with 5 beats buffered, mid-packet.
  - Expect tvalid=0 and level=0 immediately, without a clock.
  - After release, a new 4-beat packet frames from idx 0.
